fpu_mul_norm_rnd_pipe: RTL

- Parametrised post-normalise/round back end for the FPU multiply pipe.
- Takes the raw significand product plus a normalisation shift count and direction from the exponent logic. Shifts left or right, extracts guard and sticky bits, rounds in one of four IEEE modes at double or single precision, and handles overflow saturation.
- Three-stage pipeline with a valid/ready handshake, replacing the fixed-width, round-to-nearest-only stage 4/5 fraction logic.

---
 rtl/fpu_mul_norm_rnd_pipe.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/fpu_mul_norm_rnd_pipe.sv
// Post-normalise / round back end of the FPU multiply pipe.
// Three lock-step stages: input register, shift + guard/sticky extract, round + overflow saturate.
module fpu_mul_norm_rnd_pipe #(
  parameter int FRAC_W = 52,
  parameter int SNG_W  = 23,
  parameter int SH_W   = 7,
  parameter int ID_W   = 4,
  localparam int PROD_W = 2*FRAC_W+2
) (
  input  logic              rclk,
  input  logic              arst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic [SH_W-1:0]   in_shcnt,
  input  logic              in_shl,
  input  logic              in_sng,
  input  logic [1:0]        in_rmode,
  input  logic              in_sign,
  input  logic              in_of,
  input  logic [ID_W-1:0]   in_id,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FRAC_W-1:0] out_frac,
  output logic              out_cout,
  output logic              out_nx,
  output logic              out_neq0,
  output logic [ID_W-1:0]   out_id
);

  localparam logic [1:0] RM_RN = 2'd0;
  localparam logic [1:0] RM_RZ = 2'd1;
  localparam logic [1:0] RM_RP = 2'd2;
  localparam logic [1:0] RM_RM = 2'd3;

  localparam logic [FRAC_W-1:0] ONES     = {FRAC_W{1'b1}};
  localparam logic [FRAC_W-1:0] ZEROS    = {FRAC_W{1'b0}};
  localparam logic [FRAC_W-1:0] WID_ULP  = {{(FRAC_W-1){1'b0}}, 1'b1};
  localparam logic [FRAC_W-1:0] NRW_ULP  = WID_ULP << (FRAC_W-SNG_W);
  localparam logic [FRAC_W-1:0] NRW_KEEP = ~(ONES >> SNG_W);
  localparam logic [FRAC_W-1:0] NRW_LOW  = ONES >> (SNG_W+1);

  logic step_s;

  // stage 1 registers
  logic              s1_valid_r;
  logic [PROD_W-1:0] s1_prod_r;
  logic [SH_W-1:0]   s1_shcnt_r;
  logic              s1_shl_r, s1_sng_r, s1_sign_r, s1_of_r;
  logic [1:0]        s1_rmode_r;
  logic [ID_W-1:0]   s1_id_r;

  // stage 2 combinational and registers
  logic [2*PROD_W-1:0] rsh_ext_s;
  logic [PROD_W-1:0]   t_s;
  logic [PROD_W-2:0]   n_s;
  logic                so_nz_s;
  logic [FRAC_W-1:0]   wfrac_s, frac_s;
  logic                wguard_s, wsticky_s, guard_s, sticky_s;

  logic              s2_valid_r;
  logic [FRAC_W-1:0] s2_frac_r;
  logic              s2_guard_r, s2_sticky_r, s2_neq0_r, s2_sng_r, s2_sign_r, s2_of_r;
  logic [1:0]        s2_rmode_r;
  logic [ID_W-1:0]   s2_id_r;

  // stage 3 combinational
  logic              lsb_s, inc_s, sat_s;
  logic [FRAC_W-1:0] ulp_s, inc_ulp_s;
  logic [FRAC_W:0]   sum_s;
  logic [FRAC_W-1:0] frac_nxt_s;
  logic              cout_nxt_s, nx_nxt_s, neq0_nxt_s;

  assign step_s   = ~out_valid | out_ready;
  assign in_ready = step_s;

  // Stage 1: capture the incoming beat
  always_ff @(posedge rclk or posedge arst) begin
    if (arst) begin
      s1_valid_r <= 1'b0;
      s1_prod_r  <= {PROD_W{1'b0}};
      s1_shcnt_r <= {SH_W{1'b0}};
      s1_shl_r   <= 1'b0;
      s1_sng_r   <= 1'b0;
      s1_rmode_r <= 2'd0;
      s1_sign_r  <= 1'b0;
      s1_of_r    <= 1'b0;
      s1_id_r    <= {ID_W{1'b0}};
    end else if (step_s) begin
      s1_valid_r <= in_valid;
      s1_prod_r  <= in_prod;
      s1_shcnt_r <= in_shcnt;
      s1_shl_r   <= in_shl;
      s1_sng_r   <= in_sng;
      s1_rmode_r <= in_rmode;
      s1_sign_r  <= in_sign;
      s1_of_r    <= in_of;
      s1_id_r    <= in_id;
    end
  end

  // Shift, normalise by one, and split into fraction / guard / sticky
  always_comb begin
    rsh_ext_s = {s1_prod_r, {PROD_W{1'b0}}} >> s1_shcnt_r;
    t_s       = {PROD_W{1'b0}};
    so_nz_s   = 1'b0;
    if (s1_shl_r) begin
      t_s = s1_prod_r << s1_shcnt_r;
    end else if (s1_shcnt_r >= SH_W'(PROD_W)) begin
      so_nz_s = |s1_prod_r;
    end else begin
      t_s     = rsh_ext_s[2*PROD_W-1 -: PROD_W];
      so_nz_s = |rsh_ext_s[PROD_W-1:0];
    end
    // hidden bit sits at PROD_W-1 after this step and is dropped
    if (t_s[PROD_W-1]) begin
      n_s = t_s[PROD_W-2:0];
    end else begin
      n_s = {t_s[PROD_W-3:0], 1'b0};
    end
    wfrac_s   = n_s[PROD_W-2 -: FRAC_W];
    wguard_s  = n_s[PROD_W-2-FRAC_W];
    wsticky_s = (|n_s[PROD_W-3-FRAC_W:0]) | so_nz_s;
    if (s1_sng_r) begin
      frac_s   = wfrac_s & NRW_KEEP;
      guard_s  = wfrac_s[FRAC_W-SNG_W-1];
      sticky_s = (|(wfrac_s & NRW_LOW)) | wguard_s | wsticky_s;
    end else begin
      frac_s   = wfrac_s;
      guard_s  = wguard_s;
      sticky_s = wsticky_s;
    end
  end

  // Stage 2: hold the extracted fields for rounding
  always_ff @(posedge rclk or posedge arst) begin
    if (arst) begin
      s2_valid_r  <= 1'b0;
      s2_frac_r   <= ZEROS;
      s2_guard_r  <= 1'b0;
      s2_sticky_r <= 1'b0;
      s2_neq0_r   <= 1'b0;
      s2_sng_r    <= 1'b0;
      s2_rmode_r  <= 2'd0;
      s2_sign_r   <= 1'b0;
      s2_of_r     <= 1'b0;
      s2_id_r     <= {ID_W{1'b0}};
    end else if (step_s) begin
      s2_valid_r  <= s1_valid_r;
      s2_frac_r   <= frac_s;
      s2_guard_r  <= guard_s;
      s2_sticky_r <= sticky_s;
      s2_neq0_r   <= (|wfrac_s) | wguard_s | wsticky_s;
      s2_sng_r    <= s1_sng_r;
      s2_rmode_r  <= s1_rmode_r;
      s2_sign_r   <= s1_sign_r;
      s2_of_r     <= s1_of_r;
      s2_id_r     <= s1_id_r;
    end
  end

  // Rounding increment, carry and overflow saturation
  always_comb begin
    lsb_s = s2_sng_r ? s2_frac_r[FRAC_W-SNG_W] : s2_frac_r[0];
    ulp_s = s2_sng_r ? NRW_ULP : WID_ULP;
    case (s2_rmode_r)
      RM_RN:   inc_s = s2_guard_r & (s2_sticky_r | lsb_s);
      RM_RZ:   inc_s = 1'b0;
      RM_RP:   inc_s = ~s2_sign_r & (s2_guard_r | s2_sticky_r);
      RM_RM:   inc_s = s2_sign_r & (s2_guard_r | s2_sticky_r);
      default: inc_s = 1'b0;
    endcase
    inc_ulp_s = inc_s ? ulp_s : ZEROS;
    sum_s     = {1'b0, s2_frac_r} + {1'b0, inc_ulp_s};
    // saturate to max finite when rounding direction points toward zero
    sat_s = (s2_rmode_r == RM_RZ) | ((s2_rmode_r == RM_RP) & s2_sign_r)
          | ((s2_rmode_r == RM_RM) & ~s2_sign_r);
    if (s2_of_r) begin
      frac_nxt_s = sat_s ? (s2_sng_r ? NRW_KEEP : ONES) : ZEROS;
      cout_nxt_s = 1'b0;
      nx_nxt_s   = 1'b1;
      neq0_nxt_s = 1'b1;
    end else begin
      frac_nxt_s = sum_s[FRAC_W-1:0];
      cout_nxt_s = sum_s[FRAC_W];
      nx_nxt_s   = s2_guard_r | s2_sticky_r;
      neq0_nxt_s = s2_neq0_r;
    end
  end

  // Stage 3: registered result
  always_ff @(posedge rclk or posedge arst) begin
    if (arst) begin
      out_valid <= 1'b0;
      out_frac  <= ZEROS;
      out_cout  <= 1'b0;
      out_nx    <= 1'b0;
      out_neq0  <= 1'b0;
      out_id    <= {ID_W{1'b0}};
    end else if (step_s) begin
      out_valid <= s2_valid_r;
      out_frac  <= frac_nxt_s;
      out_cout  <= cout_nxt_s;
      out_nx    <= nx_nxt_s;
      out_neq0  <= neq0_nxt_s;
      out_id    <= s2_id_r;
    end
  end

endmodule
